// File: rtl/aud_fir_feeder.sv
// aud_fir_feeder
//   Takes completed WM8978 receive words, converts each from WL-bit to OUT_W-bit
//   signed (optional round-half-up, positive saturation), buffers the results in a
//   first-word-fall-through FIFO and hands them to the FIR over valid/ready.
//   Samples dropped on a full FIFO are counted.
// Ports
//   aud_bclk   : clock, rising edge
//   rst        : synchronous active-high reset
//   rx_done    : sample strobe, one sample per high cycle
//   adc_data   : sample word, adc_data[WL-1:0] is the two's complement sample
//   fir_ready  : FIR consumes the head sample this cycle
//   clr_ovf    : clears overflow / drop_cnt (a same-cycle drop takes priority)
//   fir_valid  : FIFO non-empty
//   fir_data   : head sample, 0 when empty
//   fifo_level : occupancy 0..DEPTH
//   overflow   : sticky drop flag
//   drop_cnt   : dropped-sample count, saturating
module aud_fir_feeder #(
  parameter int WL    = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8,
  parameter int ROUND = 1
) (
  input  logic                     aud_bclk,
  input  logic                     rst,
  input  logic                     rx_done,
  input  logic [31:0]              adc_data,
  input  logic                     fir_ready,
  input  logic                     clr_ovf,
  output logic                     fir_valid,
  output logic [OUT_W-1:0]         fir_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int SH = WL - OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // ---------------- stage 1: width conversion ----------------
  logic [WL-1:0]    s;
  logic [OUT_W-1:0] conv;
  assign s = adc_data[WL-1:0];

  generate
    if (WL < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^adc_data[31:WL];
    end

    if (SH == 0) begin : g_pass
      assign conv = s;
    end else if (ROUND != 0) begin : g_round
      localparam logic [WL:0] HALF = {{WL{1'b0}}, 1'b1} << (SH-1);
      logic [WL:0]    sum;
      logic [OUT_W:0] t;
      logic           unused_lo;
      // One guard bit keeps the +half carry; the shifted value is OUT_W+1 wide.
      assign sum       = {s[WL-1], s} + HALF;
      assign t         = sum[WL:SH];
      assign unused_lo = ^sum[SH-1:0];
      // Only positive overflow is reachable: top two bits 01 means T > max.
      assign conv = (t[OUT_W:OUT_W-1] == 2'b01) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                : t[OUT_W-1:0];
    end else begin : g_trunc
      logic unused_lo;
      assign unused_lo = ^s[SH-1:0];
      assign conv      = s[WL-1:SH];
    end
  endgenerate

  logic [OUT_W-1:0] cv_data_q;
  logic             cv_valid_q;

  // Data needs no reset: it is only consumed when cv_valid_q is set.
  always_ff @(posedge aud_bclk) begin
    if (rx_done) cv_data_q <= conv;
  end

  // ---------------- stage 2: FIFO ----------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;
  logic             rd, wr, drop;

  assign fir_valid = (cnt_q != '0);
  assign rd        = fir_valid & fir_ready;
  assign wr        = cv_valid_q & ((cnt_q != FULL) | rd);
  assign drop      = cv_valid_q & (cnt_q == FULL) & ~rd;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // A drop in the clear cycle wins: the count restarts at 1.
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge aud_bclk) begin
    if (wr) mem[wr_ptr_q] <= cv_data_q;
  end

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      cv_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      cv_valid_q <= rx_done;
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign fir_data   = fir_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = cnt_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_aud_fir_feeder.sv
module tb_aud_fir_feeder;
  logic        aud_bclk = 1'b0;
  logic        rst, rx_done, fir_ready, clr_ovf;
  logic [31:0] adc_data;

  // main instance: WL=24, OUT_W=16, ROUND=1
  logic        v1, ov1;
  logic [15:0] d1, dc1;
  logic [3:0]  l1;
  // truncating instance: WL=24, OUT_W=16, ROUND=0
  logic        v0, ov0;
  logic [15:0] d0, dc0;
  logic [3:0]  l0;
  // pass-through instance: WL=OUT_W=16
  logic        v16, ov16;
  logic [15:0] d16, dc16;
  logic [3:0]  l16;

  int vectors = 0;
  int miscompares = 0;

  always #5 aud_bclk = ~aud_bclk;

  aud_fir_feeder #(.WL(24), .OUT_W(16), .DEPTH(8), .ROUND(1)) u_r1 (
    .aud_bclk(aud_bclk), .rst(rst), .rx_done(rx_done), .adc_data(adc_data),
    .fir_ready(fir_ready), .clr_ovf(clr_ovf), .fir_valid(v1), .fir_data(d1),
    .fifo_level(l1), .overflow(ov1), .drop_cnt(dc1));

  aud_fir_feeder #(.WL(24), .OUT_W(16), .DEPTH(8), .ROUND(0)) u_r0 (
    .aud_bclk(aud_bclk), .rst(rst), .rx_done(rx_done), .adc_data(adc_data),
    .fir_ready(fir_ready), .clr_ovf(clr_ovf), .fir_valid(v0), .fir_data(d0),
    .fifo_level(l0), .overflow(ov0), .drop_cnt(dc0));

  aud_fir_feeder #(.WL(16), .OUT_W(16), .DEPTH(8), .ROUND(1)) u_16 (
    .aud_bclk(aud_bclk), .rst(rst), .rx_done(rx_done), .adc_data(adc_data),
    .fir_ready(fir_ready), .clr_ovf(clr_ovf), .fir_valid(v16), .fir_data(d16),
    .fifo_level(l16), .overflow(ov16), .drop_cnt(dc16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle 1 time unit before sampling/driving
  task automatic tick();
    @(posedge aud_bclk);
    #1;
  endtask

  task automatic conv_vec(input logic [31:0] din, input logic [15:0] exp1,
                          input logic [15:0] exp0, input logic chk0, input string tag);
    rx_done = 1'b1; adc_data = din; fir_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    chk({tag, " valid"}, {31'd0, v1}, 32'd1);
    chk({tag, " r1"}, {16'd0, d1}, {16'd0, exp1});
    if (chk0) chk({tag, " r0"}, {16'd0, d0}, {16'd0, exp0});
  endtask

  logic [15:0] exp_q[$];

  initial begin
    rst = 1'b1; rx_done = 1'b0; fir_ready = 1'b0; clr_ovf = 1'b0; adc_data = '0;
    tick(); tick();
    // reset state
    chk("rst fir_valid", {31'd0, v1}, 32'd0);
    chk("rst fir_data", {16'd0, d1}, 32'd0);
    chk("rst level", {28'd0, l1}, 32'd0);
    chk("rst overflow", {31'd0, ov1}, 32'd0);
    chk("rst drop_cnt", {16'd0, dc1}, 32'd0);
    rst = 1'b0;
    tick();

    // conversion: rounding, saturation, negative full-scale, truncation
    conv_vec(32'h0012_3480, 16'h1235, 16'h1234, 1'b1, "c123480");
    conv_vec(32'h0012_347F, 16'h1234, 16'h1234, 1'b1, "c12347F");
    conv_vec(32'h007F_FF80, 16'h7FFF, 16'h7FFF, 1'b0, "c7FFF80");
    conv_vec(32'h0080_0000, 16'h8000, 16'h8000, 1'b1, "c800000");
    conv_vec(32'h00FF_FF80, 16'h0000, 16'hFFFF, 1'b1, "cFFFF80");
    conv_vec(32'h0000_ABCD, 16'h00AC, 16'h00AB, 1'b1, "c00ABCD");
    chk("wl16 pass", {16'd0, d16}, 32'h0000_ABCD);
    fir_ready = 1'b1; tick(); tick();
    chk("drained", {28'd0, l1}, 32'd0);

    // fill 8 then drop the 9th
    fir_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      rx_done = 1'b1; adc_data = i << 8;
      tick();
    end
    rx_done = 1'b0;
    tick();
    chk("fill level", {28'd0, l1}, 32'd8);
    chk("fill overflow", {31'd0, ov1}, 32'd1);
    chk("fill drop_cnt", {16'd0, dc1}, 32'd1);
    fir_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d valid", i), {31'd0, v1}, 32'd1);
      chk($sformatf("drain%0d data", i), {16'd0, d1}, i);
      tick();
    end
    chk("drain empty", {31'd0, v1}, 32'd0);
    chk("drain data0", {16'd0, d1}, 32'd0);

    // full with simultaneous read and write
    fir_ready = 1'b0;
    for (int i = 'h11; i <= 'h18; i++) begin
      rx_done = 1'b1; adc_data = i << 8;
      tick();
    end
    rx_done = 1'b1; adc_data = 32'h55 << 8;
    tick();
    chk("rw full level", {28'd0, l1}, 32'd8);
    rx_done = 1'b0; fir_ready = 1'b1;
    chk("rw head", {16'd0, d1}, 32'h11);
    tick();
    chk("rw level", {28'd0, l1}, 32'd8);
    chk("rw drop_cnt", {16'd0, dc1}, 32'd1);
    for (int i = 'h12; i <= 'h18; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0055);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rw out%0d", i), {16'd0, d1}, {16'd0, exp_q[i]});
      tick();
    end
    chk("rw empty", {31'd0, v1}, 32'd0);

    // clr_ovf alone, then clr_ovf colliding with a drop
    fir_ready = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr overflow", {31'd0, ov1}, 32'd0);
    chk("clr drop_cnt", {16'd0, dc1}, 32'd0);
    for (int i = 1; i <= 13; i++) begin
      rx_done = 1'b1; adc_data = i << 8;
      tick();
    end
    rx_done = 1'b0;
    tick();
    chk("drop5 cnt", {16'd0, dc1}, 32'd5);
    chk("drop5 ovf", {31'd0, ov1}, 32'd1);
    chk("drop5 level", {28'd0, l1}, 32'd8);
    rx_done = 1'b1; adc_data = 32'h0000_7700;
    tick();
    rx_done = 1'b0; clr_ovf = 1'b1;
    tick();
    chk("clr+drop ovf", {31'd0, ov1}, 32'd1);
    chk("clr+drop cnt", {16'd0, dc1}, 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("clr2 ovf", {31'd0, ov1}, 32'd0);
    chk("clr2 cnt", {16'd0, dc1}, 32'd0);
    chk("clr2 level", {28'd0, l1}, 32'd8);

    // reset mid-stream
    fir_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pre-rst empty", {28'd0, l1}, 32'd0);
    fir_ready = 1'b0;
    for (int i = 'h21; i <= 'h24; i++) begin
      rx_done = 1'b1; adc_data = i << 8;
      tick();
    end
    chk("pre-rst level", {28'd0, l1}, 32'd3);
    rst = 1'b1; adc_data = 32'h25 << 8;
    tick();
    chk("mid-rst valid", {31'd0, v1}, 32'd0);
    chk("mid-rst data", {16'd0, d1}, 32'd0);
    chk("mid-rst level", {28'd0, l1}, 32'd0);
    chk("mid-rst ovf", {31'd0, ov1}, 32'd0);
    chk("mid-rst cnt", {16'd0, dc1}, 32'd0);
    rst = 1'b0; adc_data = 32'h26 << 8;
    tick();
    rx_done = 1'b0;
    chk("post-rst 1cyc", {31'd0, v1}, 32'd0);
    tick();
    chk("post-rst valid", {31'd0, v1}, 32'd1);
    chk("post-rst data", {16'd0, d1}, 32'h26);
    chk("post-rst level", {28'd0, l1}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
